exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Iterative RV32M multiply/divide execute unit, parametrised in data width, sitting beside the single-cycle execute stage. It takes a decoded M-extension op with register operands from id, computes it over several cycles, and stalls pc through `hold_o` while busy. It then writes the result to the register file through the same `rd_*` write port style as the execute stage. A `flush_i` input lets a concurrent jump kill an op in flight.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; any even value ≥ 8.
- `REG_ADDR_W`, 5: destination register address width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: valid M-extension op presented by id.
- `op_i`  in  3: funct3; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_rdata_i`  in  XLEN: operand A / dividend.
- `rs2_rdata_i`  in  XLEN: operand B / divisor.
- `rd_waddr_i`  in  REG_ADDR_W: destination register.
- `flush_i`  in  1: abort current op, no writeback.
- `hold_o`  out  1: stall request to pc/id (combinational).
- `busy_o`  out  1: state ≠ IDLE.
- `rd_we_o`  out  1: register write enable, one-cycle pulse.
- `rd_waddr_o`  out  REG_ADDR_W: write address.
- `rd_wdata_o`  out  XLEN: write data.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - On `start_i & !flush_i`, latch op, rd address, and operand magnitudes.
    - Signed operands (MULH/DIV/REM: both; MULHSU: rs1 only) are converted to absolute value, and the result sign flag is recorded.
    - MUL uses low-half semantics, so signedness is irrelevant to it.
  - Special divide cases skip CALC and go to DONE with the fixed result:
    - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
    - Signed overflow (DIV/REM with dividend = 1 followed by XLEN-1 zeros, divisor = all ones): quotient = dividend, remainder = 0.
  - Otherwise go to CALC with a counter loaded to XLEN.
- CALC: one iteration per cycle, counter decrements, DONE when the counter reaches 1 → exactly XLEN cycles.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle; the remainder register is XLEN+1 bits wide.
- Entering DONE, apply the final sign fix-up:
  - Product negated (2·XLEN two's complement) if the sign flag is set.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
- DONE (one cycle): `rd_we_o`=1, `rd_waddr_o`/`rd_wdata_o` = result. Always → IDLE. `start_i` in DONE is the same instruction still in id and is ignored.
- `rd_waddr_i` = 0 still runs the op normally; the x0 write is suppressed by the register file, not here.
- `flush_i` in CALC → IDLE next cycle with no writeback. `flush_i` in DONE has no effect; the result is committed.
- `hold_o` = (IDLE & `start_i` & !`flush_i` & !special) | CALC. It is 0 in DONE, so id loads the next instruction at the end of the DONE cycle.

## Timing
- Reset: state IDLE; `hold_o`=0, `busy_o`=0, `rd_we_o`=0, `rd_waddr_o`=0, `rd_wdata_o`=0; counter and datapath registers cleared.
- `rst` has priority over `flush_i` and `start_i`. Reset mid-CALC → IDLE next cycle, no writeback.
- Normal op accepted at edge E0: CALC for cycles 1..XLEN; `rd_we_o` high in cycle XLEN+1 after acceptance. Latency XLEN+1 cycles (33 for XLEN=32).
- Special divide case: `rd_we_o` high in the cycle after acceptance. Latency 1; `hold_o` never asserted.
- `rd_we_o`, `rd_waddr_o` and `rd_wdata_o` are registered.
  - `rd_we_o` drops the cycle after DONE.
  - `rd_wdata_o` and `rd_waddr_o` hold their last value until the next DONE.
- Back-to-back ops: earliest next acceptance is the cycle after DONE, so there is no idle cycle beyond the DONE→IDLE transition.
- All arithmetic is modulo 2^XLEN on results; no exceptions are raised.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32 → `rd_wdata_o`=0xFFFFFFEB with `rd_we_o` in cycle 33; `hold_o` high cycles 0–32.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF, REM 0x1234 / 0 → 0x1234, and DIV 0x80000000 / 0xFFFFFFFF → 0x80000000: each with `rd_we_o` one cycle after start and `hold_o` never high.
- `flush_i` at cycle 10 of a MUL → `busy_o`=0 at cycle 11, no `rd_we_o` pulse. `rst` at cycle 20 of a DIV → all outputs 0 next cycle. A following op still produces a correct result.
- XLEN=8 build: MUL 0x0F × 0x11 → 0xFF in cycle 9. `start_i` held high through DONE → exactly one writeback.

Source files
------------

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, XLEN cycles per op.
// Latency XLEN+1 (1 for divide-by-zero/overflow); hold_o stalls pc/id while an op is computing.
module exe_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_rdata_i,
  input  logic [XLEN-1:0]       rs2_rdata_i,
  input  logic [REG_ADDR_W-1:0] rd_waddr_i,
  input  logic                  flush_i,
  output logic                  hold_o,
  output logic                  busy_o,
  output logic                  rd_we_o,
  output logic [REG_ADDR_W-1:0] rd_waddr_o,
  output logic [XLEN-1:0]       rd_wdata_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]      r_cnt;
  logic [XLEN-1:0]       r_hi, r_lo, r_b;
  logic                  r_sa, r_sb;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_wdata;

  logic                  w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]       w_a_mag, w_b_mag;
  logic                  w_div0, w_ovf, w_special, w_accept, w_last;
  logic [XLEN-1:0]       w_spec_res;

  assign w_is_div  = op_i[2];
  assign w_a_sgn   = (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
  assign w_b_sgn   = (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
  assign w_a_neg   = w_a_sgn & rs1_rdata_i[XLEN-1];
  assign w_b_neg   = w_b_sgn & rs2_rdata_i[XLEN-1];
  assign w_a_mag   = w_a_neg ? -rs1_rdata_i : rs1_rdata_i;
  assign w_b_mag   = w_b_neg ? -rs2_rdata_i : rs2_rdata_i;

  assign w_div0    = w_is_div & (rs2_rdata_i == '0);
  assign w_ovf     = w_is_div & ~op_i[0] & (rs1_rdata_i == MIN_NEG) & (rs2_rdata_i == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (op_i[1] ? rs1_rdata_i : '1)
                             : (op_i[1] ? '0 : rs1_rdata_i);

  assign w_accept  = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_last    = (r_state == S_CALC) & ~flush_i & (r_cnt == CNT_ONE);

  // r_lo holds the multiplier (shifted out) or dividend (shifted into quotient).
  logic [XLEN:0]   w_mul_sum, w_rem_sh;
  logic [XLEN-1:0] w_diff, w_hi_nxt, w_lo_nxt;
  logic            w_ge;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;
  assign w_hi_nxt  = r_op[2] ? (w_ge ? w_diff : w_rem_sh[XLEN-1:0]) : w_mul_sum[XLEN:1];
  assign w_lo_nxt  = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_mul_sum[0], r_lo[XLEN-1:1]};

  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_calc_res;

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo_s  = (r_sa ^ r_sb) ? -w_lo_nxt : w_lo_nxt;
  assign w_rem_s  = r_sa ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_calc_res = '0;
    case (r_op)
      3'd0:                w_calc_res = w_prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_calc_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_calc_res = w_quo_s;
      default:             w_calc_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (flush_i) w_state_nxt = S_IDLE;
               else if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hold_o = ((r_state == S_IDLE) & start_i & ~flush_i & ~w_special) | (r_state == S_CALC);
    busy_o = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_op  <= op_i;
        r_rd  <= rd_waddr_i;
        r_cnt <= CNT_INIT;
        r_hi  <= '0;
        r_lo  <= w_a_mag;
        r_b   <= w_b_mag;
        r_sa  <= w_a_neg;
        r_sb  <= w_b_neg;
        if (w_special) begin
          r_we    <= 1'b1;
          r_waddr <= rd_waddr_i;
          r_wdata <= w_spec_res;
        end
      end else if ((r_state == S_CALC) && !flush_i) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt - CNT_ONE;
        if (w_last) begin
          r_we    <= 1'b1;
          r_waddr <= r_rd;
          r_wdata <= w_calc_res;
        end
      end
    end
  end

  assign rd_we_o    = r_we;
  assign rd_waddr_o = r_waddr;
  assign rd_wdata_o = r_wdata;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: XLEN=32 instance for results/timing/flush/reset, XLEN=8 for short-op timing.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        hold_o, busy_o, rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;

  logic        s_start, s_flush;
  logic [2:0]  s_op;
  logic [7:0]  s_a, s_b;
  logic [4:0]  s_rd;
  logic        s_hold, s_busy, s_we;
  logic [4:0]  s_waddr;
  logic [7:0]  s_wdata;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_rdata_i(rs1), .rs2_rdata_i(rs2), .rd_waddr_i(rd_in), .flush_i(flush_i),
    .hold_o(hold_o), .busy_o(busy_o), .rd_we_o(rd_we_o),
    .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o)
  );

  exe_muldiv #(.XLEN(8), .REG_ADDR_W(5)) dut8 (
    .clk(clk), .rst(rst), .start_i(s_start), .op_i(s_op),
    .rs1_rdata_i(s_a), .rs2_rdata_i(s_b), .rd_waddr_i(s_rd), .flush_i(s_flush),
    .hold_o(s_hold), .busy_o(s_busy), .rd_we_o(s_we),
    .rd_waddr_o(s_waddr), .rd_wdata_o(s_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in cycle 0, then follows it to writeback and one cycle beyond.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input bit special);
    int cyc;
    bit hold_ok;
    op_i = op; rs1 = a; rs2 = b; rd_in = rd; start_i = 1'b1;
    @(negedge clk);
    hold_ok = (hold_o === !special);
    step();
    start_i = 1'b0;
    cyc = 1;
    while (rd_we_o !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      if (hold_o !== 1'b1) hold_ok = 1'b0;
      step();
      cyc++;
    end
    @(negedge clk);
    if (hold_o !== 1'b0) hold_ok = 1'b0;
    check({tag, "_lat"}, 32'(cyc), special ? 32'd1 : 32'd33);
    check({tag, "_data"}, rd_wdata_o, exp);
    check({tag, "_addr"}, 32'(rd_waddr_o), 32'(rd));
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    step();
    check({tag, "_we_drop"}, 32'(rd_we_o), 32'd0);
    check({tag, "_data_kept"}, rd_wdata_o, exp);
  endtask

  initial begin
    int cyc;
    int n_we;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    s_start = 1'b0; s_flush = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_rd = '0;
    step();
    step();
    check("rst_hold", 32'(hold_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_we", 32'(rd_we_o), 32'd0);
    check("rst_waddr", 32'(rd_waddr_o), 32'd0);
    check("rst_wdata", rd_wdata_o, 32'd0);
    rst = 1'b0;
    step();

    do_op("mul_neg",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b0);
    do_op("mul_shift", 3'd0, 32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780, 1'b0);
    do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 1'b0);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF, 1'b0);
    do_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 1'b0);
    do_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 1'b0);
    do_op("div_negb",  3'd4, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_negb",  3'd6, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,         1'b0);
    do_op("divu",      3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        1'b0);
    do_op("remu",      3'd7, 32'd100,       32'd7,         5'd0,  32'd2,         1'b0);
    do_op("divu_z",    3'd5, 32'h0000_1234, 32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
    do_op("rem_z",     3'd6, 32'h0000_1234, 32'd0,         5'd14, 32'h0000_1234, 1'b1);
    do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
    do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1);

    // Flush a MUL in cycle 10 of its run.
    op_i = 3'd0; rs1 = 32'd5; rs2 = 32'd6; rd_in = 5'd17; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    check("flush_busy_pre", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy_post", 32'(busy_o), 32'd0);
    check("flush_hold_post", 32'(hold_o), 32'd0);
    n_we = 0;
    repeat (40) begin
      if (rd_we_o === 1'b1) n_we++;
      step();
    end
    check("flush_no_we", 32'(n_we), 32'd0);
    do_op("after_flush", 3'd0, 32'd5, 32'd6, 5'd18, 32'd30, 1'b0);

    // Reset in cycle 20 of a DIV.
    op_i = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd19; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    check("mrst_hold", 32'(hold_o), 32'd0);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_we", 32'(rd_we_o), 32'd0);
    check("mrst_waddr", 32'(rd_waddr_o), 32'd0);
    check("mrst_wdata", rd_wdata_o, 32'd0);
    rst = 1'b0;
    n_we = 0;
    repeat (40) begin
      if (rd_we_o === 1'b1) n_we++;
      step();
    end
    check("mrst_no_we", 32'(n_we), 32'd0);
    do_op("after_rst", 3'd4, 32'd1000, 32'd3, 5'd20, 32'd333, 1'b0);

    // XLEN=8: start held high through DONE must still give a single writeback.
    s_op = 3'd0; s_a = 8'h0F; s_b = 8'h11; s_rd = 5'd21; s_start = 1'b1;
    step();
    cyc = 1;
    while (s_we !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    check("x8_lat", 32'(cyc), 32'd9);
    check("x8_data", 32'(s_wdata), 32'h0000_00FF);
    check("x8_addr", 32'(s_waddr), 32'd21);
    step();
    s_start = 1'b0;
    n_we = 0;
    repeat (20) begin
      if (s_we === 1'b1) n_we++;
      step();
    end
    check("x8_single_we", 32'(n_we), 32'd0);
    check("x8_idle", 32'(s_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
